// File: rtl/arm_pipe_pkg.sv
// Shared pipeline definitions for the fetch stage.
//   INSTR_W / ADDR_W : instruction and address widths
//   fetch_state_e    : fetch FSM states (FETCH issues requests, DROP waits
//                      out the response of a request made stale by a branch)
//   fetch_entry_t    : one prefetch queue entry {pc of next instr, instruction}
//   word_align       : clears the byte-offset bits of an address
package arm_pipe_pkg;

    localparam int INSTR_W = 32;
    localparam int ADDR_W  = 32;

    typedef enum logic {
        FETCH = 1'b0,
        DROP  = 1'b1
    } fetch_state_e;

    typedef struct packed {
        logic [ADDR_W-1:0]  pc;
        logic [INSTR_W-1:0] instr;
    } fetch_entry_t;

    function automatic logic [ADDR_W-1:0] word_align(input logic [ADDR_W-1:0] addr);
        return {addr[ADDR_W-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/if_prefetch_queue.sv
// Synchronous FIFO holding fetched {pc, instruction} entries.
// Ports:
//   clk, rst     : clock, asynchronous active-low reset
//   push, push_data : write an entry (ignored when full unless popping too)
//   pop          : discard the head entry (ignored when empty)
//   flush        : empty the queue; wins over push and pop
//   head_data    : current head entry (meaningless when empty)
//   count        : number of valid entries
//   full, empty  : occupancy flags
module if_prefetch_queue
    import arm_pipe_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          push,
    input  logic [ADDR_W+INSTR_W-1:0]     push_data,
    input  logic                          pop,
    input  logic                          flush,
    output logic [ADDR_W+INSTR_W-1:0]     head_data,
    output logic [$clog2(DEPTH+1)-1:0]    count,
    output logic                          full,
    output logic                          empty
);

    localparam int ENT_W = ADDR_W + INSTR_W;
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [PTR_W-1:0] LAST_PTR  = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);

    logic [ENT_W-1:0] mem_q [DEPTH];
    logic [ENT_W-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
    endfunction

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        do_pop   = pop && (count_q != '0);
        // A full queue can still accept a write when the head leaves this cycle.
        do_push  = push && ((count_q != DEPTH_CNT) || do_pop);

        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q] = push_data;
                wr_ptr_d        = ptr_inc(wr_ptr_q);
            end
            if (do_pop) begin
                rd_ptr_d = ptr_inc(rd_ptr_q);
            end
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign head_data = mem_q[rd_ptr_q];
    assign count     = count_q;
    assign full      = (count_q == DEPTH_CNT);
    assign empty     = (count_q == '0);

endmodule

// File: rtl/if_stage_prefetch.sv
// Instruction-fetch stage with a small prefetch queue.
// Issues one outstanding request at a time to instruction memory, buffers
// returned words and presents the oldest one to decode.
// Ports:
//   clk, rst                 : clock, asynchronous active-low reset
//   freeze                   : decode stall, holds the presented entry
//   branch_taken/branch_addr : redirect from execute (target is word aligned here)
//   imem_req/imem_addr       : request to memory
//   imem_ack/imem_rdata      : memory completion and data
//   valid/pc/instruction     : head entry for decode (pc = instr address + 4)
//   dbg_state                : current fetch FSM state (0 FETCH, 1 DROP)
//
// Memory handshake: a word moves when imem_req && imem_ack are both high in
// the same cycle (ack may arrive in the cycle req first rises). Once imem_req
// is high, it and imem_addr stay unchanged until that transfer; the memory
// must accept imem_req falling without an ack only when reset is asserted.
module if_stage_prefetch
    import arm_pipe_pkg::*;
#(
    parameter int                DEPTH    = 2,
    parameter logic [ADDR_W-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        freeze,
    input  logic        branch_taken,
    input  logic [31:0] branch_addr,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        valid,
    output logic [31:0] pc,
    output logic [31:0] instruction,
    output logic        dbg_state
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);

    fetch_state_e      state_q, state_d;
    logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
    logic [ADDR_W-1:0] drop_addr_q, drop_addr_d;
    // Keeps imem_req low while reset is held and until the first edge after it.
    logic              run_q, run_d;

    logic              q_push;
    logic              q_pop;
    logic              q_flush;
    logic [CNT_W-1:0]  q_count;
    logic              q_full;
    logic              q_empty;
    fetch_entry_t      push_entry;
    fetch_entry_t      head_entry;

    always_comb begin
        state_d     = state_q;
        fetch_pc_d  = fetch_pc_q;
        drop_addr_d = drop_addr_q;
        run_d       = 1'b1;
        imem_req    = 1'b0;
        imem_addr   = fetch_pc_q;
        q_push      = 1'b0;
        q_flush     = 1'b0;
        push_entry  = '{pc: fetch_pc_q + ADDR_W'(4), instr: imem_rdata};

        case (state_q)
            FETCH: begin
                // Depends only on registered state; the count can only grow via
                // an ack, so an unacked request naturally stays raised.
                imem_req  = run_q && (q_count < DEPTH_CNT);
                imem_addr = fetch_pc_q;
                if (branch_taken) begin
                    q_flush    = 1'b1;
                    fetch_pc_d = word_align(branch_addr);
                    if (imem_req && !imem_ack) begin
                        // Request is now stale but must still complete.
                        state_d     = DROP;
                        drop_addr_d = fetch_pc_q;
                    end
                end else if (imem_req && imem_ack) begin
                    q_push     = 1'b1;
                    fetch_pc_d = fetch_pc_q + ADDR_W'(4);
                end
            end
            DROP: begin
                imem_req  = 1'b1;
                imem_addr = drop_addr_q;
                if (branch_taken) begin
                    q_flush    = 1'b1;
                    fetch_pc_d = word_align(branch_addr);
                end
                if (imem_ack) begin
                    state_d = FETCH;
                end
            end
            default: begin
                state_d = FETCH;
            end
        endcase
    end

    assign q_pop = !q_empty && !freeze && !branch_taken;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= FETCH;
            fetch_pc_q  <= RESET_PC;
            drop_addr_q <= '0;
            run_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            fetch_pc_q  <= fetch_pc_d;
            drop_addr_q <= drop_addr_d;
            run_q       <= run_d;
        end
    end

    if_prefetch_queue #(
        .DEPTH (DEPTH)
    ) u_queue (
        .clk       (clk),
        .rst       (rst),
        .push      (q_push),
        .push_data (push_entry),
        .pop       (q_pop),
        .flush     (q_flush),
        .head_data (head_entry),
        .count     (q_count),
        .full      (q_full),
        .empty     (q_empty)
    );

    assign valid       = (q_count != '0) && !q_full ? 1'b1 : q_full;
    assign pc          = valid ? head_entry.pc    : '0;
    assign instruction = valid ? head_entry.instr : '0;
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_if_stage_prefetch.sv
module tb_if_stage_prefetch;

    localparam int DEPTH = 2;

    // ---------------- clock / reset ----------------
    logic clk;
    logic rst;
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- DUT (RESET_PC = 0) ----------------
    logic        freeze, branch_taken, imem_ack;
    logic [31:0] branch_addr, imem_rdata;
    logic        imem_req, valid, dbg_state;
    logic [31:0] imem_addr, pc, instruction;

    if_stage_prefetch #(.DEPTH(DEPTH), .RESET_PC(32'h0000_0000)) dut (
        .clk          (clk),
        .rst          (rst),
        .freeze       (freeze),
        .branch_taken (branch_taken),
        .branch_addr  (branch_addr),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_ack     (imem_ack),
        .imem_rdata   (imem_rdata),
        .valid        (valid),
        .pc           (pc),
        .instruction  (instruction),
        .dbg_state    (dbg_state)
    );

    // ---------------- DUT with wrapping reset PC ----------------
    logic        ack_w;
    logic [31:0] rdata_w;
    logic        req_w, valid_w, dbg_w;
    logic [31:0] addr_w, pc_w, instr_w;

    if_stage_prefetch #(.DEPTH(DEPTH), .RESET_PC(32'hFFFF_FFFC)) dut_w (
        .clk          (clk),
        .rst          (rst),
        .freeze       (1'b0),
        .branch_taken (1'b0),
        .branch_addr  (32'h0),
        .imem_req     (req_w),
        .imem_addr    (addr_w),
        .imem_ack     (ack_w),
        .imem_rdata   (rdata_w),
        .valid        (valid_w),
        .pc           (pc_w),
        .instruction  (instr_w),
        .dbg_state    (dbg_w)
    );

    // ---------------- scoreboard / reference model ----------------
    int checks = 0;
    int errors = 0;

    // Each entry is {pc_of_next_instr, instruction}; front is what decode sees.
    logic [63:0] exp_q[$];
    bit          m_run;        // first edge after reset has happened
    bit          m_drop;       // a stale request is still waiting for its ack
    logic [31:0] m_pc;         // next fetch address
    logic [31:0] m_drop_addr;  // address of the stale request

    task automatic model_reset(input logic [31:0] rpc);
        exp_q.delete();
        m_run       = 0;
        m_drop      = 0;
        m_pc        = rpc;
        m_drop_addr = '0;
    endtask

    function automatic bit m_req();
        return m_drop || (m_run && (exp_q.size() < DEPTH));
    endfunction

    function automatic logic [31:0] m_addr();
        return m_drop ? m_drop_addr : m_pc;
    endfunction

    // Applies one clock edge worth of architectural effect.
    task automatic model_edge(input bit fz, input bit br, input logic [31:0] ba,
                              input bit ak, input logic [31:0] rd);
        bit req  = m_req();
        bit xfer = req && ak;
        if (br) begin
            exp_q.delete();
            if (m_drop) begin
                if (xfer) m_drop = 0;
            end else if (req && !ak) begin
                m_drop      = 1;
                m_drop_addr = m_pc;
            end
            m_pc = ba & 32'hFFFF_FFFC;
        end else begin
            if (exp_q.size() > 0 && !fz) void'(exp_q.pop_front());
            if (m_drop) begin
                if (xfer) m_drop = 0;
            end else if (xfer) begin
                exp_q.push_back({m_pc + 32'd4, rd});
                m_pc = m_pc + 32'd4;
            end
        end
        m_run = 1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic compare_all();
        logic [63:0] h;
        bit          v;
        v = (exp_q.size() > 0);
        h = v ? exp_q[0] : 64'h0;
        chk("imem_req", {31'b0, imem_req}, {31'b0, m_req()});
        if (m_req()) chk("imem_addr", imem_addr, m_addr());
        chk("valid", {31'b0, valid}, {31'b0, v});
        chk("pc", pc, h[63:32]);
        chk("instruction", instruction, h[31:0]);
        chk("drop_state", {31'b0, dbg_state}, {31'b0, m_drop});
    endtask

    // ---------------- driver ----------------
    task automatic step(input bit fz, input bit br, input logic [31:0] ba,
                        input bit ak, input logic [31:0] rd);
        freeze       = fz;
        branch_taken = br;
        branch_addr  = ba;
        imem_ack     = ak;
        imem_rdata   = rd;
        model_edge(fz, br, ba, ak, rd);
        @(posedge clk);
        #1;
        compare_all();
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        rst = 1'b0;
        freeze = 0; branch_taken = 0; branch_addr = 0; imem_ack = 0; imem_rdata = 0;
        ack_w = 0; rdata_w = 0;
        model_reset(32'h0);

        // Reset held
        repeat (2) @(posedge clk);
        #1;
        chk("rst_req", {31'b0, imem_req}, 32'd0);
        chk("rst_valid", {31'b0, valid}, 32'd0);
        chk("rst_pc", pc, 32'h0);
        chk("rst_instr", instruction, 32'h0);
        chk("w_rst_req", {31'b0, req_w}, 32'd0);

        // Release: request rises at the first edge
        rst = 1'b1;
        #1;
        chk("rel_req_before_edge", {31'b0, imem_req}, 32'd0);
        step(0, 0, 0, 0, 0);
        chk("rel_req", {31'b0, imem_req}, 32'd1);
        chk("rel_addr", imem_addr, 32'h0);
        chk("w_first_addr", addr_w, 32'hFFFF_FFFC);

        // Zero-wait stream; wrap instance takes its single ack in parallel
        ack_w = 1; rdata_w = 32'h5A5A_0001;
        step(0, 0, 0, 1, 32'hA000_0000);
        chk("s_instr0", instruction, 32'hA000_0000);
        chk("s_pc0", pc, 32'h4);
        chk("w_pc_wrap", pc_w, 32'h0);
        chk("w_instr", instr_w, 32'h5A5A_0001);
        chk("w_addr_wrap", addr_w, 32'h0);
        ack_w = 0;
        step(0, 0, 0, 1, 32'hA000_0001);
        chk("s_instr1", instruction, 32'hA000_0001);
        chk("s_pc1", pc, 32'h8);
        step(0, 0, 0, 1, 32'hA000_0002);
        chk("s_instr2", instruction, 32'hA000_0002);
        chk("s_pc2", pc, 32'hC);
        step(0, 0, 0, 0, 0);

        // Freeze with ack always high: queue fills, request drops, head held
        for (int i = 0; i < 4; i++) step(1, 0, 0, 1, 32'hB000_0000 + i);
        chk("fz_req_low", {31'b0, imem_req}, 32'd0);
        chk("fz_head", instruction, 32'hB000_0000);
        chk("fz_pc", pc, 32'h10);
        for (int i = 4; i < 10; i++) step(0, 0, 0, 1, 32'hB000_0000 + i);

        // Branch while a request is pending
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0);
        chk("br_req_pending", {31'b0, imem_req}, 32'd1);
        step(0, 1, 32'h103, 0, 0);
        chk("br_drop", {31'b0, dbg_state}, 32'd1);
        chk("br_valid", {31'b0, valid}, 32'd0);
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 1, 32'hDEAD_BEEF);
        chk("br_next_addr", imem_addr, 32'h100);
        chk("br_junk_valid", {31'b0, valid}, 32'd0);
        step(0, 0, 0, 1, 32'hC000_0000);
        chk("br_first_pc", pc, 32'h104);
        chk("br_first_instr", instruction, 32'hC000_0000);

        // Branch + freeze + ack together with one entry queued
        step(1, 1, 32'h100, 1, 32'hBAD0_0001);
        chk("bfa_valid", {31'b0, valid}, 32'd0);
        chk("bfa_addr", imem_addr, 32'h100);
        chk("bfa_state", {31'b0, dbg_state}, 32'd0);

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            step($urandom_range(0, 3) == 0, $urandom_range(0, 11) == 0, $urandom,
                 $urandom_range(0, 1) == 1, $urandom);
        end

        // Reset in the middle of traffic
        freeze = 0; branch_taken = 0; imem_ack = 0;
        #2 rst = 1'b0;
        #1;
        chk("mid_rst_req", {31'b0, imem_req}, 32'd0);
        chk("mid_rst_valid", {31'b0, valid}, 32'd0);
        chk("mid_rst_pc", pc, 32'h0);
        chk("mid_rst_instr", instruction, 32'h0);
        model_reset(32'h0);
        @(posedge clk);
        #1 rst = 1'b1;
        step(0, 0, 0, 0, 0);
        chk("mid_rel_addr", imem_addr, 32'h0);
        for (int i = 0; i < 200; i++) begin
            step($urandom_range(0, 2) == 0, $urandom_range(0, 15) == 0, $urandom,
                 $urandom_range(0, 2) != 0, $urandom);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
